// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
// Shares one single-port SRAM between the scan loader (LD), the pseudo-SPI
// reader (SPI) and the serial CPU. Ownership is held in a registered owner
// FSM; the SRAM pins are a combinational mux from that registered owner,
// gated by the owner's live REQ. SPI and CPU tenures are bounded by a hold
// counter whenever someone else is waiting; the loader is never revoked.
//
// Handshake: a master raises REQ_x and holds A_x/D_x/WE_x stable until GNT_x
// is seen high. Every cycle with GNT_x=1 and REQ_x=1 is one issued SRAM
// access. Dropping REQ_x for one cycle releases ownership at the next edge.
// Reads return data one cycle later, tagged by VLD_x.

module sram_port_arbiter #(
  parameter int MEMORY_DATA_WIDTH = 8,
  parameter int MEMORY_ADDR_WIDTH = 10,
  parameter int MAX_HOLD          = 16
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         REQ_LD,
  input  logic                         REQ_SPI,
  input  logic                         REQ_CPU,
  input  logic                         WE_LD,
  input  logic                         WE_SPI,
  input  logic                         WE_CPU,
  input  logic [MEMORY_ADDR_WIDTH-1:0] A_LD,
  input  logic [MEMORY_ADDR_WIDTH-1:0] A_SPI,
  input  logic [MEMORY_ADDR_WIDTH-1:0] A_CPU,
  input  logic [MEMORY_DATA_WIDTH-1:0] D_LD,
  input  logic [MEMORY_DATA_WIDTH-1:0] D_SPI,
  input  logic [MEMORY_DATA_WIDTH-1:0] D_CPU,
  input  logic [MEMORY_DATA_WIDTH-1:0] Q_from_SRAM,
  output logic                         GNT_LD,
  output logic                         GNT_SPI,
  output logic                         GNT_CPU,
  output logic                         VLD_LD,
  output logic                         VLD_SPI,
  output logic                         VLD_CPU,
  output logic [MEMORY_DATA_WIDTH-1:0] RDATA,
  output logic                         CEN,
  output logic                         WEN,
  output logic [MEMORY_ADDR_WIDTH-1:0] A,
  output logic [MEMORY_DATA_WIDTH-1:0] D,
  output logic                         CPU_WAIT,
  output logic [1:0]                   dbg_state
);

  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LD   = 2'd1,
    ST_SPI  = 2'd2,
    ST_CPU  = 2'd3
  } state_t;

  state_t                       state_q, state_d;
  logic [HW-1:0]                hold_q, hold_d;
  logic [2:0]                   vld_q, vld_d;

  logic                         owner_req;
  logic                         owner_we;
  logic [MEMORY_ADDR_WIDTH-1:0] owner_a;
  logic [MEMORY_DATA_WIDTH-1:0] owner_d;
  logic                         others_req;
  logic                         bounded_owner;
  logic                         revoke;

  // Fixed-priority pick: LD > SPI > CPU, IDLE when nobody is asking.
  function automatic state_t pick(input logic ld, input logic spi, input logic cpu);
    if (ld)       return ST_LD;
    else if (spi) return ST_SPI;
    else if (cpu) return ST_CPU;
    else          return ST_IDLE;
  endfunction

  // Select the current owner's request lines and note whether anyone else waits.
  always_comb begin
    owner_req  = 1'b0;
    owner_we   = 1'b0;
    owner_a    = '0;
    owner_d    = '0;
    others_req = 1'b0;
    unique case (state_q)
      ST_IDLE: others_req = REQ_LD | REQ_SPI | REQ_CPU;
      ST_LD: begin
        owner_req  = REQ_LD;
        owner_we   = WE_LD;
        owner_a    = A_LD;
        owner_d    = D_LD;
        others_req = REQ_SPI | REQ_CPU;
      end
      ST_SPI: begin
        owner_req  = REQ_SPI;
        owner_we   = WE_SPI;
        owner_a    = A_SPI;
        owner_d    = D_SPI;
        others_req = REQ_LD | REQ_CPU;
      end
      ST_CPU: begin
        owner_req  = REQ_CPU;
        owner_we   = WE_CPU;
        owner_a    = A_CPU;
        owner_d    = D_CPU;
        others_req = REQ_LD | REQ_SPI;
      end
    endcase
  end

  // Only SPI and CPU tenures are bounded; the loader keeps the SRAM until it lets go.
  assign bounded_owner = (state_q == ST_SPI) || (state_q == ST_CPU);
  assign revoke        = bounded_owner && owner_req && others_req &&
                         (hold_q >= HW'(MAX_HOLD - 1));

  // Owner state register.
  always_ff @(posedge CLK) begin
    if (!RST_N) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next owner: arbitrate from IDLE, on release, or on revocation (revoked master excluded).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: state_d = pick(REQ_LD, REQ_SPI, REQ_CPU);
      ST_LD:   if (!REQ_LD)            state_d = pick(1'b0, REQ_SPI, REQ_CPU);
      ST_SPI:  if (!REQ_SPI || revoke) state_d = pick(REQ_LD, 1'b0, REQ_CPU);
      ST_CPU:  if (!REQ_CPU || revoke) state_d = pick(REQ_LD, REQ_SPI, 1'b0);
    endcase
  end

  // Grants decode the registered owner; the pins carry an access only while the owner requests.
  always_comb begin
    GNT_LD   = (state_q == ST_LD);
    GNT_SPI  = (state_q == ST_SPI);
    GNT_CPU  = (state_q == ST_CPU);
    CPU_WAIT = REQ_CPU & ~GNT_CPU;
    CEN      = 1'b1;
    WEN      = 1'b1;
    A        = '0;
    D        = '0;
    if (owner_req) begin
      CEN = 1'b0;
      WEN = ~owner_we;
      A   = owner_a;
      D   = owner_d;
    end
  end

  // Hold count restarts with each new owner; read tag marks which master gets next cycle's data.
  always_comb begin
    hold_d = hold_q;
    if (state_d != state_q)
      hold_d = '0;
    else if (owner_req && bounded_owner && (hold_q < HW'(MAX_HOLD)))
      hold_d = hold_q + HW'(1);
    vld_d = 3'b000;
    if (owner_req && !owner_we)
      vld_d = {state_q == ST_CPU, state_q == ST_SPI, state_q == ST_LD};
  end

  // Hold counter and read-tag registers; reset drops any read still in flight.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      hold_q <= '0;
      vld_q  <= 3'b000;
    end else begin
      hold_q <= hold_d;
      vld_q  <= vld_d;
    end
  end

  assign VLD_LD    = vld_q[0];
  assign VLD_SPI   = vld_q[1];
  assign VLD_CPU   = vld_q[2];
  assign RDATA     = Q_from_SRAM;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: a cycle-by-cycle vector table, hand-written
// sequences for multi-cycle corners, and a randomized phase checked against
// an owner/tenure reference model with a shadow memory.

module tb_sram_port_arbiter;

  localparam int DW = 8;
  localparam int AW = 10;
  localparam int MAX_HOLD = 4;
  localparam int N_RAND = 3000;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // master inputs, index 0 = LD, 1 = SPI, 2 = CPU
  logic          req  [3];
  logic          we   [3];
  logic [AW-1:0] a_in [3];
  logic [DW-1:0] d_in [3];

  logic          gnt_ld, gnt_spi, gnt_cpu, vld_ld, vld_spi, vld_cpu;
  logic [DW-1:0] rdata, q_from_sram;
  logic          cen, wen, cpu_wait;
  logic [AW-1:0] a_pin;
  logic [DW-1:0] d_pin;
  logic [1:0]    dbg_state;
  logic [2:0]    gnt_bus, vld_bus;

  assign gnt_bus = {gnt_cpu, gnt_spi, gnt_ld};
  assign vld_bus = {vld_cpu, vld_spi, vld_ld};

  sram_port_arbiter #(
    .MEMORY_DATA_WIDTH(DW),
    .MEMORY_ADDR_WIDTH(AW),
    .MAX_HOLD(MAX_HOLD)
  ) dut (
    .CLK(clk), .RST_N(rst_n),
    .REQ_LD(req[0]), .REQ_SPI(req[1]), .REQ_CPU(req[2]),
    .WE_LD(we[0]), .WE_SPI(we[1]), .WE_CPU(we[2]),
    .A_LD(a_in[0]), .A_SPI(a_in[1]), .A_CPU(a_in[2]),
    .D_LD(d_in[0]), .D_SPI(d_in[1]), .D_CPU(d_in[2]),
    .Q_from_SRAM(q_from_sram),
    .GNT_LD(gnt_ld), .GNT_SPI(gnt_spi), .GNT_CPU(gnt_cpu),
    .VLD_LD(vld_ld), .VLD_SPI(vld_spi), .VLD_CPU(vld_cpu),
    .RDATA(rdata), .CEN(cen), .WEN(wen), .A(a_pin), .D(d_pin),
    .CPU_WAIT(cpu_wait), .dbg_state(dbg_state)
  );

  // SRAM macro model: one-cycle read latency
  logic [DW-1:0] sram_mem [0:(1<<AW)-1];
  initial begin
    for (int i = 0; i < (1 << AW); i++) sram_mem[i] = 8'(i * 7 + 3);
    sram_mem[10'h3A5] = 8'h5C;
  end
  always @(posedge clk) begin
    if (!cen) begin
      if (!wen) sram_mem[a_pin] <= d_pin;
      else      q_from_sram     <= sram_mem[a_pin];
    end
  end

  // ---------------- scoreboard / counters ----------------
  int total = 0;
  int bad   = 0;
  logic [AW+1:0] exp_q [$];
  logic [AW+1:0] obs_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic all_quiet();
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b0;
      we[i]  = 1'b0;
    end
  endtask

  task automatic set_req(input logic [2:0] r, input logic [2:0] w);
    for (int i = 0; i < 3; i++) begin
      req[i] = r[i];
      we[i]  = w[i];
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          rst_n;
    logic [2:0]    req;    // {cpu, spi, ld}
    logic [2:0]    we;
    logic [2:0]    gnt;
    logic [2:0]    vld;
    logic          cen;
    logic          wen;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          wt;
  } vec_t;

  vec_t vecs [15];

  // ---------------- reference model ----------------
  int            m_owner;   // -1 none, else master index
  int            m_run;     // accesses issued in the current tenure
  int            m_vld;     // master whose read returns this cycle, -1 none
  logic [DW-1:0] m_rexp;
  logic [DW-1:0] shadow [16];

  function automatic int first_req(input int excl);
    for (int j = 0; j < 3; j++)
      if (j != excl && req[j]) return j;
    return -1;
  endfunction

  task automatic model_check_and_step();
    logic issue, others;
    int   o, nxt, idx;
    o     = m_owner;
    issue = 1'b0;
    if (o >= 0) issue = req[o];
    chk("rnd_gnt",  gnt_bus, (o >= 0) ? 32'(1 << o) : 0);
    chk("rnd_cen",  cen, !issue);
    chk("rnd_wen",  wen, issue ? 32'(!we[o]) : 1);
    chk("rnd_a",    a_pin, issue ? 32'(a_in[o]) : 0);
    chk("rnd_d",    d_pin, issue ? 32'(d_in[o]) : 0);
    chk("rnd_wait", cpu_wait, req[2] && (o != 2));
    chk("rnd_vld",  vld_bus, (m_vld >= 0) ? 32'(1 << m_vld) : 0);
    if (m_vld >= 0) chk("rnd_rdata", rdata, m_rexp);
    // what happens at the coming edge
    m_vld = -1;
    if (issue) begin
      idx = int'(a_in[o]) - 'h380;
      if (we[o]) shadow[idx] = d_in[o];
      else begin
        m_vld  = o;
        m_rexp = shadow[idx];
      end
    end
    others = 1'b0;
    for (int j = 0; j < 3; j++) if (j != o && req[j]) others = 1'b1;
    nxt = o;
    if (o < 0)                                                nxt = first_req(-1);
    else if (!req[o])                                         nxt = first_req(o);
    else if (o != 0 && (m_run + 1) >= MAX_HOLD && others)     nxt = first_req(o);
    if (nxt != o)   m_run = 0;
    else if (issue) m_run++;
    m_owner = nxt;
  endtask

  task automatic rand_drive();
    for (int i = 0; i < 3; i++) begin
      if (!req[i]) begin
        if ($urandom_range(3) == 0) begin
          req[i]  = 1'b1;
          we[i]   = 1'($urandom_range(1));
          a_in[i] = 10'h380 + 10'($urandom_range(15));
          d_in[i] = 8'($urandom);
        end
      end else if (m_owner == i) begin
        if ($urandom_range(3) == 0) req[i] = 1'b0;
        else if ($urandom_range(1) == 1) begin
          we[i]   = 1'($urandom_range(1));
          a_in[i] = 10'h380 + 10'($urandom_range(15));
          d_in[i] = 8'($urandom);
        end
      end
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  logic issued;
  logic [1:0] own_code;
  logic [AW+1:0] e, o_v;
  logic cpu_raised;

  initial begin
    rst_n = 1'b0;
    all_quiet();
    a_in[0] = 10'h000; d_in[0] = 8'h11;
    a_in[1] = 10'h022; d_in[1] = 8'h22;
    a_in[2] = 10'h3A5; d_in[2] = 8'h33;

    //           rst   req     we      gnt     vld     cen   wen   a        d      wait
    vecs[0]  = '{1'b0, 3'b111, 3'b000, 3'b000, 3'b000, 1'b1, 1'b1, 10'h000, 8'h00, 1'b1};
    vecs[1]  = '{1'b0, 3'b111, 3'b000, 3'b000, 3'b000, 1'b1, 1'b1, 10'h000, 8'h00, 1'b1};
    vecs[2]  = '{1'b1, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1, 1'b1, 10'h000, 8'h00, 1'b0};
    vecs[3]  = '{1'b1, 3'b100, 3'b000, 3'b000, 3'b000, 1'b1, 1'b1, 10'h000, 8'h00, 1'b1};
    vecs[4]  = '{1'b1, 3'b100, 3'b000, 3'b100, 3'b000, 1'b0, 1'b1, 10'h3A5, 8'h33, 1'b0};
    vecs[5]  = '{1'b1, 3'b000, 3'b000, 3'b100, 3'b100, 1'b1, 1'b1, 10'h000, 8'h00, 1'b0};
    vecs[6]  = '{1'b1, 3'b101, 3'b001, 3'b000, 3'b000, 1'b1, 1'b1, 10'h000, 8'h00, 1'b1};
    vecs[7]  = '{1'b1, 3'b101, 3'b001, 3'b001, 3'b000, 1'b0, 1'b0, 10'h000, 8'h11, 1'b1};
    vecs[8]  = '{1'b1, 3'b100, 3'b001, 3'b001, 3'b000, 1'b1, 1'b1, 10'h000, 8'h00, 1'b1};
    vecs[9]  = '{1'b1, 3'b100, 3'b000, 3'b100, 3'b000, 1'b0, 1'b1, 10'h3A5, 8'h33, 1'b0};
    vecs[10] = '{1'b1, 3'b110, 3'b000, 3'b100, 3'b100, 1'b0, 1'b1, 10'h3A5, 8'h33, 1'b0};
    vecs[11] = '{1'b1, 3'b010, 3'b000, 3'b100, 3'b100, 1'b1, 1'b1, 10'h000, 8'h00, 1'b0};
    vecs[12] = '{1'b1, 3'b010, 3'b000, 3'b010, 3'b000, 1'b0, 1'b1, 10'h022, 8'h22, 1'b0};
    vecs[13] = '{1'b1, 3'b000, 3'b000, 3'b010, 3'b010, 1'b1, 1'b1, 10'h000, 8'h00, 1'b0};
    vecs[14] = '{1'b1, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1, 1'b1, 10'h000, 8'h00, 1'b0};

    repeat (2) @(posedge clk);
    #1;

    // table: one row per cycle
    for (int i = 0; i < 15; i++) begin
      rst_n = vecs[i].rst_n;
      set_req(vecs[i].req, vecs[i].we);
      @(negedge clk);
      chk($sformatf("vec%0d_gnt", i),  gnt_bus,  vecs[i].gnt);
      chk($sformatf("vec%0d_vld", i),  vld_bus,  vecs[i].vld);
      chk($sformatf("vec%0d_cen", i),  cen,      vecs[i].cen);
      chk($sformatf("vec%0d_wen", i),  wen,      vecs[i].wen);
      chk($sformatf("vec%0d_a", i),    a_pin,    vecs[i].a);
      chk($sformatf("vec%0d_d", i),    d_pin,    vecs[i].d);
      chk($sformatf("vec%0d_wait", i), cpu_wait, vecs[i].wt);
      next_cycle();
    end

    // CPU read of preloaded word: wait only in the request cycle
    a_in[2] = 10'h3A5; we[2] = 1'b0; req[2] = 1'b1;
    @(negedge clk);
    chk("cpurd_wait_n", cpu_wait, 1);
    chk("cpurd_gnt_n",  gnt_cpu, 0);
    next_cycle();
    @(negedge clk);
    chk("cpurd_gnt_n1",  gnt_cpu, 1);
    chk("cpurd_cen_n1",  cen, 0);
    chk("cpurd_a_n1",    a_pin, 10'h3A5);
    chk("cpurd_wait_n1", cpu_wait, 0);
    next_cycle();
    req[2] = 1'b0;
    @(negedge clk);
    chk("cpurd_vld_n2",   vld_cpu, 1);
    chk("cpurd_rdata_n2", rdata, 8'h5C);
    chk("cpurd_wait_n2",  cpu_wait, 0);
    next_cycle();

    // read back the loader's earlier write to 0x000
    a_in[2] = 10'h000; req[2] = 1'b1;
    next_cycle();
    next_cycle();
    req[2] = 1'b0;
    @(negedge clk);
    chk("prio_readback_vld",   vld_cpu, 1);
    chk("prio_readback_rdata", rdata, 8'h11);
    next_cycle();
    next_cycle();

    // revocation: SPI streams, CPU arrives after SPI's first access
    a_in[1] = 10'h100; we[1] = 1'b0; req[1] = 1'b1;
    a_in[2] = 10'h3A5; we[2] = 1'b0;
    cpu_raised = 1'b0;
    exp_q.delete();
    obs_q.delete();
    for (int k = 0; k < 4; k++) exp_q.push_back({2'd1, 10'h100 + 10'(k)});
    exp_q.push_back({2'd2, 10'h3A5});
    exp_q.push_back({2'd1, 10'h104});
    exp_q.push_back({2'd1, 10'h105});
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      issued   = !cen;
      own_code = gnt_ld ? 2'd0 : gnt_spi ? 2'd1 : gnt_cpu ? 2'd2 : 2'd3;
      if (issued) obs_q.push_back({own_code, a_pin});
      next_cycle();
      if (issued && own_code == 2'd1) begin
        a_in[1] = a_in[1] + 10'd1;
        if (!cpu_raised) begin
          req[2]     = 1'b1;
          cpu_raised = 1'b1;
        end
      end
      if (issued && own_code == 2'd2) req[2] = 1'b0;
    end
    req[1] = 1'b0;
    req[2] = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() == 0) begin
        chk("revoke_missing_access", 0, e);
      end else begin
        o_v = obs_q.pop_front();
        chk("revoke_seq", o_v, e);
      end
    end
    next_cycle();
    next_cycle();

    // loader holds for 40 writes with SPI and CPU pending
    a_in[0] = 10'h200; d_in[0] = 8'h00; we[0] = 1'b1;
    a_in[1] = 10'h022; we[1] = 1'b0;
    set_req(3'b111, 3'b001);
    next_cycle();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk($sformatf("ld_hold%0d_gnt", i), {gnt_bus, cen, wen}, {3'b001, 1'b0, 1'b0});
      chk($sformatf("ld_hold%0d_a", i), a_pin, 10'h200 + 10'(i));
      next_cycle();
      a_in[0] = a_in[0] + 10'd1;
      d_in[0] = d_in[0] + 8'd1;
    end
    req[0] = 1'b0;
    @(negedge clk);
    chk("ld_release_gnt", gnt_bus, 3'b001);
    chk("ld_release_cen", cen, 1);
    next_cycle();
    @(negedge clk);
    chk("ld_after_gnt", gnt_bus, 3'b010);
    chk("ld_after_cen", cen, 0);
    next_cycle();
    all_quiet();
    next_cycle();
    next_cycle();

    // reset in the cycle a CPU read issues
    a_in[2] = 10'h3A5; we[2] = 1'b0; req[2] = 1'b1;
    next_cycle();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstmid_cen_in_reset", cen, 0);
    chk("rstmid_gnt_in_reset", gnt_cpu, 1);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid_vld", vld_bus, 0);
    chk("rstmid_gnt", gnt_bus, 0);
    chk("rstmid_cen", cen, 1);
    chk("rstmid_state", dbg_state, 0);
    chk("rstmid_wait", cpu_wait, 1);
    next_cycle();
    all_quiet();
    next_cycle();

    // randomized phase against the reference model
    rst_n = 1'b0;
    next_cycle();
    rst_n   = 1'b1;
    m_owner = -1;
    m_run   = 0;
    m_vld   = -1;
    m_rexp  = '0;
    for (int i = 0; i < 16; i++) shadow[i] = 8'(('h380 + i) * 7 + 3);
    for (int c = 0; c < N_RAND; c++) begin
      @(negedge clk);
      model_check_and_step();
      next_cycle();
      rand_drive();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Registered arbiter that shares the single-port instruction/data SRAM among three masters: the scan loader (SRAM_IO_CTRL), the pseudo-SPI output reader, and the serial CPU. It replaces the static CTRL_BGN/spi_MUX steering with ownership-based grants, bounded hold time and per-master read-data valid. It also generates the CPU_WAIT stall. It sits between the masters and the SRAM macro pins inside the SCPU/ALU/CTRL/SPI top level.

## Interface
- MEMORY_DATA_WIDTH, 8, SRAM word width
- MEMORY_ADDR_WIDTH, 10, SRAM address width
- MAX_HOLD, 16, maximum consecutive owned cycles for SPI or CPU while another master waits (≥2)
- CLK  in  1  system clock, all logic on rising edge
- RST_N  in  1  synchronous active-low reset
- REQ_LD / REQ_SPI / REQ_CPU  in  1 each  access request; held high for the whole burst
- WE_LD / WE_SPI / WE_CPU  in  1 each  1 = write, 0 = read
- A_LD / A_SPI / A_CPU  in  MEMORY_ADDR_WIDTH each  access address
- D_LD / D_SPI / D_CPU  in  MEMORY_DATA_WIDTH each  write data
- Q_from_SRAM  in  MEMORY_DATA_WIDTH  SRAM read data, valid one cycle after a read command
- GNT_LD / GNT_SPI / GNT_CPU  out  1 each  registered ownership grant; one-hot or all zero
- VLD_LD / VLD_SPI / VLD_CPU  out  1 each  RDATA belongs to this master this cycle
- RDATA  out  MEMORY_DATA_WIDTH  Q_from_SRAM passed through combinationally
- CEN  out  1  SRAM chip enable, active low
- WEN  out  1  SRAM write enable, active low
- A  out  MEMORY_ADDR_WIDTH  SRAM address
- D  out  MEMORY_DATA_WIDTH  SRAM write data
- CPU_WAIT  out  1  REQ_CPU & ~GNT_CPU, combinational

## Operation
- Owner FSM states: IDLE, OWN_LD, OWN_SPI, OWN_CPU. GNT_x is the decode of the state register.
- Arbitration runs in IDLE and whenever the current owner releases or is revoked. Priority is LD > SPI > CPU. The revoked master is excluded from that single arbitration.
- Release: the owner's REQ is low in a cycle. At the next edge the state moves directly to the winner among the other pending REQs, with no idle cycle, or to IDLE if none are pending.
- Pin drive:
  - An access is issued only when the owner's REQ is high: CEN=0, WEN=~WE_owner, A=A_owner, D=D_owner.
  - Otherwise CEN=1, WEN=1, A=0, D=0.
  - The mux is driven from the registered state. REQ gates it combinationally.
- Hold counter:
  - Clears on every ownership change. Increments on each issued access by SPI or CPU, saturating at MAX_HOLD.
  - When it reaches MAX_HOLD-1 and any other REQ is pending, the owner is revoked at the next edge.
  - The revoked master keeps REQ high and re-wins by normal arbitration.
- OWN_LD is never revoked. The loader is a test/boot path and always wins the first arbitration it enters.
- Read tag: a registered one-hot copy of (owner & REQ & ~WE). VLD_x is that register, aligned with Q_from_SRAM.
- Writes produce no VLD.

## Timing
- Reset (RST_N low at an edge) leaves:
  - state IDLE
  - GNT_* = 0, VLD_* = 0, hold counter 0
  - CEN=1, WEN=1, A=0, D=0, CPU_WAIT = REQ_CPU
- Grant latency: REQ_x rises in cycle n with state IDLE. GNT_x=1 and x's first access appears on the pins in cycle n+1.
- Read latency: an access issued in cycle k gives VLD_x=1 with RDATA valid in cycle k+1. Back-to-back reads sustain one word per cycle.
- Handover: owner x drops REQ in cycle m with y pending. GNT_x=0 and GNT_y=1 in cycle m+1, and y issues in m+1. No SRAM access is issued in cycle m.
- Revocation: with the counter at MAX_HOLD-1 in cycle r and another REQ pending, the owner issues in r and loses GNT in r+1. An owner issues at most MAX_HOLD consecutive accesses while another master waits.
- Simultaneous REQs in IDLE are resolved by priority only.
- Reset mid-burst: an access in the reset cycle still drives the pins combinationally. The cycle after, everything is idle and VLD is not asserted for the aborted read.
- A master must not change A/D/WE while its REQ is high and GNT is low. The arbiter samples nothing before grant.

## Test plan
- Reset: hold RST_N low 2 cycles with all REQs high -> GNT_*=0, VLD_*=0, CEN=1, WEN=1, A=0, D=0, CPU_WAIT=1.
- CPU read: preload 0x3A5 = 0x5C, REQ_CPU, WE_CPU=0, A_CPU=0x3A5 in cycle n -> GNT_CPU and CEN=0, A=0x3A5 in n+1; VLD_CPU=1, RDATA=0x5C in n+2; CPU_WAIT=1 only in cycle n.
- Priority: REQ_LD and REQ_CPU rise in the same IDLE cycle; LD writes 0x11 to 0x000 -> GNT_LD first. When REQ_LD drops, GNT_CPU follows one cycle later with no idle cycle. A CPU read of 0x000 returns 0x11.
- Revocation (MAX_HOLD=4): SPI streams reads; REQ_CPU rises after SPI's first access -> SPI issues exactly 4 accesses. GNT_CPU is then high for one CPU access while SPI stays pending, then SPI resumes at the next address.
- Loader not revoked: LD holds REQ for 40 writes while SPI and CPU are pending -> GNT_LD stays high for all 40, and the other masters are granted only after release.
- Reset mid-read: RST_N low in the cycle a CPU read issues -> no VLD_CPU the following cycle, and state is IDLE.
